// File: rtl/trivium_keygen_pkg.sv
// Shared types, sizes and round helpers for the Trivium key generator.
// Contents:
//   trivium_state_t  - controller states
//   TRIVIUM_*        - cipher state, seed and warm-up sizes
//   trivium_round    - one Trivium round; returns {z, next_state}
//   trivium_load     - builds the 288-bit initial state from key and IV
// Bit mapping used throughout: vector bit [i-1] holds Trivium bit s(i).
package trivium_keygen_pkg;

  typedef enum logic [2:0] {
    SEED,
    LOAD,
    WARMUP,
    READY,
    GEN
  } trivium_state_t;

  localparam int TRIVIUM_STATE_W = 288;
  localparam int TRIVIUM_SEED_W  = 160;
  localparam int TRIVIUM_WARMUP  = 1152;

  // One round. Each of the three registers shifts one place towards the
  // higher index. The feedback bits enter at s1, s94 and s178.
  function automatic logic [TRIVIUM_STATE_W:0] trivium_round(
    input logic [TRIVIUM_STATE_W-1:0] s
  );
    logic t1, t2, t3, z;
    t1 = s[65]  ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90]  & s[91])  ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction

  // key[79] lands in s1 and iv[79] lands in s94. In both cases the first
  // entropy bit collected goes to the lowest Trivium index.
  function automatic logic [TRIVIUM_STATE_W-1:0] trivium_load(
    input logic [79:0] key,
    input logic [79:0] iv
  );
    logic [TRIVIUM_STATE_W-1:0] s;
    s = '0;
    for (int k = 0; k < 80; k++) begin
      s[k]      = key[79-k];
      s[93 + k] = iv[79-k];
    end
    s[287:285] = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_keygen_core.sv
// Trivium state holder, unrolled BITS_PER_CYCLE rounds per clock.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - replace the state with the key/IV initial state
//   key, iv   - 80-bit key and IV, used only when load=1
//   step      - advance the state by BITS_PER_CYCLE rounds
//   z         - keystream for the current state; the MSB is the earliest round
module trivium_core
  import trivium_keygen_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [79:0]               key,
  input  logic [79:0]               iv,
  input  logic                      step,
  output logic [BITS_PER_CYCLE-1:0] z
);

  logic [TRIVIUM_STATE_W-1:0] st;
  logic [TRIVIUM_STATE_W-1:0] st_next;
  logic [TRIVIUM_STATE_W-1:0] cur;
  logic [TRIVIUM_STATE_W:0]   rnd;

  // Chain BITS_PER_CYCLE rounds together. The keystream bit of round r goes
  // to z[BPC-1-r], so consumers can shift z in MSB-first.
  always_comb begin
    cur = st;
    rnd = '0;
    z   = '0;
    for (int r = 0; r < BITS_PER_CYCLE; r++) begin
      rnd                    = trivium_round(cur);
      z[BITS_PER_CYCLE-1-r]  = rnd[TRIVIUM_STATE_W];
      cur                    = rnd[TRIVIUM_STATE_W-1:0];
    end
    st_next = cur;
  end

  // Load takes priority over step. The controller never asserts both together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= '0;
    end else if (load) begin
      st <= trivium_load(key, iv);
    end else if (step) begin
      st <= st_next;
    end
  end

endmodule

// File: rtl/trivium_keygen.sv
// Trivium p/q key generator. It collects 160 entropy bits from the ADC
// (80-bit key followed by 80-bit IV), warms the cipher up for 1152 rounds,
// and then produces KEY_WIDTH-bit p/q pairs on request. It reseeds after
// RESEED_INTERVAL pairs, or on reseed; RESEED_INTERVAL=0 means reseed only
// on demand.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   adc_in, adc_wr  - entropy bit and its strobe (used only while collecting)
//   req             - request one p/q pair (taken only when ready=1)
//   reseed          - discard the current seed and collect a new one (READY only)
//   ready           - a req in this cycle will be accepted
//   need_seed       - entropy collection in progress
//   key_valid       - one-cycle pulse when p/q change
//   p, q            - most recent key pair
module trivium_keygen
  import trivium_keygen_pkg::*;
#(
  parameter int KEY_WIDTH       = 64,
  parameter int BITS_PER_CYCLE  = 8,
  parameter int RESEED_INTERVAL = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adc_in,
  input  logic                 adc_wr,
  input  logic                 req,
  input  logic                 reseed,
  output logic                 ready,
  output logic                 need_seed,
  output logic                 key_valid,
  output logic [KEY_WIDTH-1:0] p,
  output logic [KEY_WIDTH-1:0] q
);

  localparam int PAIR_W  = 2 * KEY_WIDTH;
  localparam int GEN_CYC = PAIR_W / BITS_PER_CYCLE;
  localparam int WU_CYC  = TRIVIUM_WARMUP / BITS_PER_CYCLE;
  localparam int CNT_MAX = (WU_CYC > GEN_CYC) ? WU_CYC : GEN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int KL_W    = (RESEED_INTERVAL < 1) ? 1 : $clog2(RESEED_INTERVAL + 1);

  trivium_state_t state, state_next;

  logic [TRIVIUM_SEED_W-1:0] seed_sr;
  logic [7:0]                seed_cnt;
  logic [CNT_W-1:0]          round_cnt;
  logic [KL_W-1:0]           keys_left;
  logic [PAIR_W-1:0]         gen_sr;
  logic                      keys_ok;
  logic                      core_load;
  logic                      core_step;
  logic                      gen_done;
  logic [BITS_PER_CYCLE-1:0] z;

  trivium_core #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .load(core_load),
    .key (seed_sr[159:80]),
    .iv  (seed_sr[79:0]),
    .step(core_step),
    .z   (z)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= state_next;
    end
  end

  // When RESEED_INTERVAL is 0, pairs are unlimited and keys_left is ignored.
  assign keys_ok = (RESEED_INTERVAL == 0) || (keys_left != '0);

  // Next-state logic and controls. GEN runs one cycle past the last core
  // step so that p/q are published together and READY is re-entered in the
  // key_valid cycle. A req held high is therefore accepted back-to-back.
  always_comb begin
    state_next = state;
    core_load  = 1'b0;
    core_step  = 1'b0;
    gen_done   = 1'b0;
    ready      = 1'b0;
    need_seed  = 1'b0;
    case (state)
      SEED: begin
        need_seed = 1'b1;
        if (adc_wr && (seed_cnt == 8'(TRIVIUM_SEED_W - 1))) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        core_load  = 1'b1;
        state_next = WARMUP;
      end
      WARMUP: begin
        core_step = 1'b1;
        if (round_cnt == CNT_W'(WU_CYC - 1)) begin
          state_next = READY;
        end
      end
      READY: begin
        ready = keys_ok;
        if (reseed || !keys_ok) begin
          state_next = SEED;
        end else if (req) begin
          state_next = GEN;
        end
      end
      GEN: begin
        if (round_cnt == CNT_W'(GEN_CYC)) begin
          gen_done   = 1'b1;
          state_next = READY;
        end else begin
          core_step = 1'b1;
        end
      end
      default: state_next = SEED;
    endcase
  end

  // Datapath: seed collection, counters, and p/q assembly. An entropy bit
  // shifts in at the LSB, so the first bit ends up in seed_sr[159].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_sr   <= '0;
      seed_cnt  <= '0;
      round_cnt <= '0;
      keys_left <= KL_W'(RESEED_INTERVAL);
      gen_sr    <= '0;
      p         <= '0;
      q         <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SEED: begin
          if (adc_wr) begin
            seed_sr  <= {seed_sr[TRIVIUM_SEED_W-2:0], adc_in};
            seed_cnt <= seed_cnt + 8'd1;
          end
        end
        LOAD: begin
          round_cnt <= '0;
          keys_left <= KL_W'(RESEED_INTERVAL);
        end
        WARMUP: begin
          round_cnt <= round_cnt + 1'b1;
        end
        READY: begin
          if (state_next == SEED) begin
            seed_cnt <= '0;
          end
          if (state_next == GEN) begin
            round_cnt <= '0;
          end
        end
        GEN: begin
          if (gen_done) begin
            p         <= gen_sr[PAIR_W-1:KEY_WIDTH];
            q         <= gen_sr[KEY_WIDTH-1:0];
            key_valid <= 1'b1;
            if (RESEED_INTERVAL != 0) begin
              keys_left <= keys_left - 1'b1;
            end
          end else begin
            gen_sr    <= {gen_sr[PAIR_W-BITS_PER_CYCLE-1:0], z};
            round_cnt <= round_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_keygen.sv
// Self-checking bench for trivium_keygen. It uses KEY_WIDTH=16,
// BITS_PER_CYCLE=4 and RESEED_INTERVAL=2. A bit-serial reference model works
// directly on s1..s288. The stimulus pushes each expected p/q pair when it
// issues a req. A monitor pops and compares the expected pair on every
// key_valid pulse.
module tb_trivium_keygen;

  localparam int KW  = 16;
  localparam int BPC = 4;
  localparam int RI  = 2;
  localparam int G   = 2 * KW / BPC;
  localparam int W   = 1152 / BPC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          adc_in = 1'b0;
  logic          adc_wr = 1'b0;
  logic          req = 1'b0;
  logic          reseed = 1'b0;
  logic          ready;
  logic          need_seed;
  logic          key_valid;
  logic [KW-1:0] p;
  logic [KW-1:0] q;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [2*KW-1:0] exp_q[$];
  bit              ms[1:288];

  trivium_keygen #(
    .KEY_WIDTH      (KW),
    .BITS_PER_CYCLE (BPC),
    .RESEED_INTERVAL(RI)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .adc_in   (adc_in),
    .adc_wr   (adc_wr),
    .req      (req),
    .reseed   (reseed),
    .ready    (ready),
    .need_seed(need_seed),
    .key_valid(key_valid),
    .p        (p),
    .q        (q)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference model. It follows the published round equations one bit at a time.
  task automatic modelRound(output bit z);
    bit t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 288; i >= 2; i--) ms[i] = ms[i-1];
    ms[1]   = t3;
    ms[94]  = t1;
    ms[178] = t2;
  endtask

  task automatic modelLoad(input logic [159:0] seed);
    bit zb;
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      ms[i]      = seed[160-i];
      ms[93 + i] = seed[80-i];
    end
    ms[286] = 1'b1;
    ms[287] = 1'b1;
    ms[288] = 1'b1;
    for (int i = 0; i < 1152; i++) modelRound(zb);
  endtask

  task automatic modelPair(output logic [2*KW-1:0] v);
    bit zb;
    v = '0;
    for (int i = 0; i < 2 * KW; i++) begin
      modelRound(zb);
      v[2*KW-1-i] = zb;
    end
  endtask

  // Scoreboard monitor. Outputs are sampled on the falling edge.
  always @(negedge clk) begin : monitor
    logic [2*KW-1:0] e;
    if (key_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_key_valid", 64'(key_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("p", 64'(p), 64'(e[2*KW-1:KW]));
        checkOutput("q", 64'(q), 64'(e[KW-1:0]));
      end
    end
  end

  // Sets the inputs for the next rising edge and returns 1 time unit after it.
  task automatic applyStimulus(input logic wr, input logic din, input logic rq, input logic rs);
    adc_wr = wr;
    adc_in = din;
    req    = rq;
    reseed = rs;
    @(posedge clk);
    #1;
  endtask

  // Writes the first nbits of seed, MSB first. With noise set, req and
  // reseed toggle at the same time; both must be ignored during SEED.
  task automatic seedBits(input logic [159:0] seed, input int nbits, input bit noise);
    for (int i = 0; i < nbits; i++) begin
      applyStimulus(1'b1, seed[159-i], noise & i[0], noise & i[1]);
    end
  endtask

  // Counts the edges from the one that sampled the last seed bit until ready
  // rises. adc_wr toggles meanwhile and must be ignored.
  task automatic waitReady(input string name);
    int lat;
    lat = 0;
    while (!ready && lat < 2000) begin
      applyStimulus(lat[0], lat[1], 1'b0, 1'b0);
      lat++;
    end
    checkOutput(name, 64'(lat), 64'(W + 1));
  endtask

  // Issues one req, with adc_wr/req/reseed noise during GEN, and checks the
  // latency to key_valid.
  task automatic requestPair(input string name);
    logic [2*KW-1:0] e;
    int lat;
    checkOutput({name, "_ready"}, 64'(ready), 64'd1);
    modelPair(e);
    exp_q.push_back(e);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    lat = 0;
    while (!key_valid && lat < 500) begin
      applyStimulus(1'b1, lat[0], lat[0], lat[1]);
      lat++;
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'(G + 1));
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_need_seed"}, 64'(need_seed), 64'd1);
    checkOutput({name, "_ready"}, 64'(ready), 64'd0);
    checkOutput({name, "_key_valid"}, 64'(key_valid), 64'd0);
    checkOutput({name, "_p"}, 64'(p), 64'd0);
    checkOutput({name, "_q"}, 64'(q), 64'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    logic [159:0]    seed_a;
    logic [159:0]    seed_b;
    logic [159:0]    seed_c;
    logic [2*KW-1:0] e;
    int              lat;
    seed_a = 160'h0;
    seed_b = 160'hDEADBEEFCAFEBABE0123_456789ABCDEF0F1E2D3C;
    seed_c = 160'h80000000000000000001_00000000000000000001;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;

    // All-zero seed, with req and reseed toggling while the seed is collected.
    seedBits(seed_a, 160, 1'b1);
    modelLoad(seed_a);
    waitReady("ready_latency_a");

    // req held high: two back-to-back pairs, then the interval is used up.
    checkOutput("held_ready", 64'(ready), 64'd1);
    modelPair(e);
    exp_q.push_back(e);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    lat = 0;
    while (!key_valid && lat < 500) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      lat++;
    end
    checkOutput("held_latency_1", 64'(lat), 64'(G + 1));
    checkOutput("held_ready_at_valid", 64'(ready), 64'd1);
    modelPair(e);
    exp_q.push_back(e);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    lat = 0;
    while (!key_valid && lat < 500) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      lat++;
    end
    checkOutput("held_latency_2", 64'(lat), 64'(G + 1));
    checkOutput("exhausted_ready", 64'(ready), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("exhausted_need_seed", 64'(need_seed), 64'd1);
    repeat (G + 4) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("dropped_req_ready", 64'(ready), 64'd0);

    // New seed after the interval is used up.
    seedBits(seed_b, 160, 1'b0);
    modelLoad(seed_b);
    waitReady("ready_latency_b");
    requestPair("pair_b");

    // reseed and req in the same cycle: reseed must win.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reseed_pre_ready", 64'(ready), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("reseed_need_seed", 64'(need_seed), 64'd1);
    checkOutput("reseed_ready", 64'(ready), 64'd0);
    repeat (G + 4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset after 70 bits: the full 160 bits are needed again.
    seedBits(seed_c, 70, 1'b0);
    adc_wr = 1'b0;
    rst    = 1'b1;
    #1;
    checkResetValues("reset_mid_seed");
    @(posedge clk);
    #1 rst = 1'b0;
    seedBits(seed_c, 160, 1'b0);
    modelLoad(seed_c);
    waitReady("ready_latency_c");

    // Reset halfway through GEN: the pending pair is never delivered.
    modelPair(e);
    exp_q.push_back(e);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (G / 2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    exp_q.delete();
    checkResetValues("reset_mid_gen");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (G + 4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_need_seed", 64'(need_seed), 64'd1);

    // Same seed again: the first pair restarts from the seed.
    seedBits(seed_c, 160, 1'b1);
    modelLoad(seed_c);
    waitReady("ready_latency_c2");
    requestPair("pair_c");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
